// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register, in-order imem word requests, PC tracking
// of in-flight requests, output FIFO to decode, redirect with stale kill.
// Ports:
//   clk, rstn                       clock / async active-low reset
//   o_imem_req_valid/i_imem_req_ready/o_imem_addr   fetch request channel
//   i_imem_rsp_valid/i_imem_rsp_data                in-order response
//   i_redirect_valid/i_redirect_pc                  restart fetch at a new PC
//   o_instr_valid/i_instr_ready/o_instruction/o_instr_pc   decode handshake
module instruction_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rstn,
  output logic            o_imem_req_valid,
  input  logic            i_imem_req_ready,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_rsp_valid,
  input  logic [XLEN-1:0] i_imem_rsp_data,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_instr_valid,
  input  logic            i_instr_ready,
  output logic [XLEN-1:0] o_instruction,
  output logic [XLEN-1:0] o_instr_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] LIM = DEPTH[CW:0];

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_npc;
  logic            r_npc_v;
  logic            r_pending;
  logic [CW-1:0]   r_inflight;
  logic [CW-1:0]   r_kill;

  logic [XLEN-1:0] r_pcq [DEPTH];
  logic [AW-1:0]   r_pcq_wp;
  logic [AW-1:0]   r_pcq_rp;

  logic [XLEN-1:0] r_fdat [DEPTH];
  logic [XLEN-1:0] r_fpc  [DEPTH];
  logic [AW-1:0]   r_fwp;
  logic [AW-1:0]   r_frp;
  logic [CW-1:0]   r_fcnt;

  logic [CW:0]     w_used;
  logic            w_credit;
  logic            w_req_valid;
  logic            w_fire;
  logic            w_hold;
  logic            w_drop;
  logic            w_wr;
  logic            w_fvalid;
  logic            w_pop;
  logic [XLEN-1:0] w_tgt;
  logic [XLEN-1:0] w_rsp_pc;
  logic [CW-1:0]   w_inflight_n;
  logic            w_unused;

  assign w_used = {1'b0, r_inflight}
                + {1'b0, r_fcnt};
  assign w_credit = w_used < LIM;

  // A request once raised is held by r_pending
  // even if the credit check later fails.
  assign w_req_valid = rstn
                     & (w_credit | r_pending);
  assign w_fire = w_req_valid & i_imem_req_ready;
  assign w_hold = w_req_valid & ~i_imem_req_ready;

  assign w_drop = i_imem_rsp_valid
                & (r_kill != '0);
  assign w_wr   = i_imem_rsp_valid
                & ~w_drop
                & ~i_redirect_valid;

  assign w_fvalid = r_fcnt != '0;
  assign w_pop    = w_fvalid & i_instr_ready;

  assign w_tgt    = {i_redirect_pc[XLEN-1:2], 2'b00};
  assign w_unused = ^i_redirect_pc[1:0];
  assign w_rsp_pc = r_pcq[r_pcq_rp];

  assign w_inflight_n = r_inflight
                      + CW'(w_fire)
                      - CW'(i_imem_rsp_valid);

  assign o_imem_req_valid = w_req_valid;
  assign o_imem_addr      = r_pc;
  assign o_instr_valid    = w_fvalid;
  assign o_instruction    = r_fdat[r_frp];
  assign o_instr_pc       = r_fpc[r_frp];

  // A redirect that lands while a request is held
  // parks its target in r_npc; the held request
  // still goes out at the old address and is
  // marked stale (r_npc_v) so it joins the kill.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc    <= RESET_PC;
      r_npc   <= RESET_PC;
      r_npc_v <= 1'b0;
    end else if (i_redirect_valid) begin
      if (w_hold) begin
        r_npc   <= w_tgt;
        r_npc_v <= 1'b1;
      end else begin
        r_pc    <= w_tgt;
        r_npc_v <= 1'b0;
      end
    end else if (w_fire) begin
      r_pc    <= r_npc_v ? r_npc
                         : r_pc + XLEN'(4);
      r_npc_v <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_inflight <= '0;
      r_kill     <= '0;
      r_pending  <= 1'b0;
    end else begin
      r_inflight <= w_inflight_n;
      r_pending  <= w_hold;
      if (i_redirect_valid) begin
        r_kill <= w_inflight_n;
      end else begin
        r_kill <= r_kill
                - CW'(w_drop)
                + CW'(w_fire & r_npc_v);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pcq_wp <= '0;
      r_pcq_rp <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pcq[i] <= '0;
      end
    end else begin
      if (w_fire) begin
        r_pcq[r_pcq_wp] <= r_pc;
        r_pcq_wp        <= r_pcq_wp + AW'(1);
      end
      if (i_imem_rsp_valid) begin
        r_pcq_rp <= r_pcq_rp + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_fwp  <= '0;
      r_frp  <= '0;
      r_fcnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_fdat[i] <= '0;
        r_fpc[i]  <= '0;
      end
    end else begin
      if (w_wr) begin
        r_fdat[r_fwp] <= i_imem_rsp_data;
        r_fpc[r_fwp]  <= w_rsp_pc;
      end
      if (i_redirect_valid) begin
        r_frp  <= r_fwp;
        r_fcnt <= '0;
      end else begin
        if (w_wr) begin
          r_fwp <= r_fwp + AW'(1);
        end
        if (w_pop) begin
          r_frp <= r_frp + AW'(1);
        end
        r_fcnt <= r_fcnt
                + CW'(w_wr)
                - CW'(w_pop);
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rstn && i_imem_rsp_valid) begin
      assert (r_inflight != '0)
        else $error("imem response with nothing in flight");
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed checks of instruction_fetch with a
// latency-programmable in-order instruction memory model.
`timescale 1ns/1ps
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        o_imem_req_valid;
  logic        i_imem_req_ready;
  logic [31:0] o_imem_addr;
  logic        i_imem_rsp_valid;
  logic [31:0] i_imem_rsp_data;
  logic        i_redirect_valid;
  logic [31:0] i_redirect_pc;
  logic        o_instr_valid;
  logic        i_instr_ready;
  logic [31:0] o_instruction;
  logic [31:0] o_instr_pc;

  always #5 clk = ~clk;

  instruction_fetch #(
    .XLEN(32),
    .RESET_PC(32'h0000_0000),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .o_imem_req_valid(o_imem_req_valid),
    .i_imem_req_ready(i_imem_req_ready),
    .o_imem_addr(o_imem_addr),
    .i_imem_rsp_valid(i_imem_rsp_valid),
    .i_imem_rsp_data(i_imem_rsp_data),
    .i_redirect_valid(i_redirect_valid),
    .i_redirect_pc(i_redirect_pc),
    .o_instr_valid(o_instr_valid),
    .i_instr_ready(i_instr_ready),
    .o_instruction(o_instruction),
    .o_instr_pc(o_instr_pc)
  );

  int n_assert = 0;
  int n_fail = 0;
  int lat = 1;
  int cyc = 0;
  int n_acc = 0;

  typedef struct {
    logic [31:0] a;
    int          due;
  } mreq_t;
  mreq_t mq[$];

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory: responds in order, lat cycles after acceptance.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mq.delete();
      i_imem_rsp_valid <= 1'b0;
      i_imem_rsp_data  <= '0;
      cyc   <= 0;
      n_acc <= 0;
    end else begin
      cyc <= cyc + 1;
      if (o_imem_req_valid && i_imem_req_ready) begin
        mq.push_back('{o_imem_addr, cyc + lat});
        n_acc <= n_acc + 1;
      end
      if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
        i_imem_rsp_valid <= 1'b1;
        i_imem_rsp_data  <= dat(mq[0].a);
        void'(mq.pop_front());
      end else begin
        i_imem_rsp_valid <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int l, input logic dr);
    rstn = 1'b0;
    i_redirect_valid = 1'b0;
    i_redirect_pc = '0;
    i_imem_req_ready = 1'b1;
    i_instr_ready = dr;
    lat = l;
    repeat (2) tick();
    rstn = 1'b1;
    #1;
  endtask

  initial begin
    i_imem_req_ready = 1'b1;
    i_redirect_valid = 1'b0;
    i_redirect_pc = '0;
    i_instr_ready = 1'b1;
    #2;
    chk("rst_req_valid", o_imem_req_valid, 0);
    chk("rst_instr_valid", o_instr_valid, 0);
    chk("rst_addr", o_imem_addr, 32'h0);
    chk("rst_instr", o_instruction, 32'h0);
    chk("rst_pc", o_instr_pc, 32'h0);

    // streaming, 1-cycle memory, decode ready
    do_reset(1, 1'b1);
    chk("t1_c0_req_valid", o_imem_req_valid, 1);
    chk("t1_c0_addr", o_imem_addr, 32'h0);
    chk("t1_c0_ivalid", o_instr_valid, 0);
    tick();
    chk("t1_c1_addr", o_imem_addr, 32'h4);
    chk("t1_c1_ivalid", o_instr_valid, 0);
    for (int k = 2; k < 8; k++) begin
      tick();
      chk("t1_ivalid", o_instr_valid, 1);
      chk("t1_pc", o_instr_pc, 32'((k - 2) * 4));
      chk("t1_instr", o_instruction, dat(32'((k - 2) * 4)));
      chk("t1_addr", o_imem_addr, 32'(k * 4));
    end

    // decode stalled: credit limit then drain
    do_reset(1, 1'b0);
    repeat (4) tick();
    chk("t2_c4_req_valid", o_imem_req_valid, 0);
    chk("t2_c4_addr", o_imem_addr, 32'h10);
    tick();
    chk("t2_c5_req_valid", o_imem_req_valid, 0);
    tick();
    chk("t2_accepted", 32'(n_acc), 32'd4);
    chk("t2_c6_ivalid", o_instr_valid, 1);
    chk("t2_c6_pc", o_instr_pc, 32'h0);
    chk("t2_c6_instr", o_instruction, dat(32'h0));
    chk("t2_c6_req_valid", o_imem_req_valid, 0);
    tick();
    chk("t2_c7_pc_stable", o_instr_pc, 32'h0);
    chk("t2_c7_instr_stable", o_instruction, dat(32'h0));
    i_instr_ready = 1'b1;
    tick();
    chk("t2_c8_pc", o_instr_pc, 32'h4);
    chk("t2_c8_req_valid", o_imem_req_valid, 1);
    chk("t2_c8_addr", o_imem_addr, 32'h10);
    tick();
    chk("t2_c9_pc", o_instr_pc, 32'h8);
    chk("t2_c9_addr", o_imem_addr, 32'h14);
    tick();
    chk("t2_c10_pc", o_instr_pc, 32'hC);
    tick();
    chk("t2_c11_pc", o_instr_pc, 32'h10);
    chk("t2_c11_instr", o_instruction, dat(32'h10));

    // redirect with 2 in flight, 1 buffered
    do_reset(2, 1'b0);
    repeat (3) tick();
    chk("t3_c3_ivalid", o_instr_valid, 1);
    chk("t3_c3_pc", o_instr_pc, 32'h0);
    i_redirect_valid = 1'b1;
    i_redirect_pc = 32'h0000_0103;
    tick();
    i_redirect_valid = 1'b0;
    chk("t3_c4_ivalid", o_instr_valid, 0);
    chk("t3_c4_req_valid", o_imem_req_valid, 1);
    chk("t3_c4_addr", o_imem_addr, 32'h100);
    tick();
    chk("t3_c5_ivalid", o_instr_valid, 0);
    chk("t3_c5_addr", o_imem_addr, 32'h104);
    tick();
    chk("t3_c6_ivalid", o_instr_valid, 0);
    tick();
    chk("t3_c7_ivalid", o_instr_valid, 1);
    chk("t3_c7_pc", o_instr_pc, 32'h100);
    chk("t3_c7_instr", o_instruction, dat(32'h100));

    // redirect while a request is held at 0x20
    do_reset(1, 1'b1);
    repeat (8) tick();
    chk("t4_c8_addr", o_imem_addr, 32'h20);
    chk("t4_c8_req_valid", o_imem_req_valid, 1);
    chk("t4_c8_pc", o_instr_pc, 32'h18);
    i_imem_req_ready = 1'b0;
    tick();
    chk("t4_c9_addr", o_imem_addr, 32'h20);
    chk("t4_c9_pc", o_instr_pc, 32'h1C);
    i_redirect_valid = 1'b1;
    i_redirect_pc = 32'h0000_0080;
    tick();
    i_redirect_valid = 1'b0;
    chk("t4_c10_addr", o_imem_addr, 32'h20);
    chk("t4_c10_req_valid", o_imem_req_valid, 1);
    chk("t4_c10_ivalid", o_instr_valid, 0);
    tick();
    chk("t4_c11_addr", o_imem_addr, 32'h20);
    i_imem_req_ready = 1'b1;
    tick();
    chk("t4_c12_addr", o_imem_addr, 32'h80);
    chk("t4_c12_ivalid", o_instr_valid, 0);
    tick();
    chk("t4_c13_ivalid", o_instr_valid, 0);
    chk("t4_c13_addr", o_imem_addr, 32'h84);
    tick();
    chk("t4_c14_ivalid", o_instr_valid, 1);
    chk("t4_c14_pc", o_instr_pc, 32'h80);
    chk("t4_c14_instr", o_instruction, dat(32'h80));

    // redirect + response + pop in one cycle
    do_reset(1, 1'b1);
    repeat (5) tick();
    chk("t5_c5_ivalid", o_instr_valid, 1);
    chk("t5_c5_pc", o_instr_pc, 32'hC);
    i_redirect_valid = 1'b1;
    i_redirect_pc = 32'h0000_0200;
    tick();
    i_redirect_valid = 1'b0;
    chk("t5_c6_ivalid", o_instr_valid, 0);
    chk("t5_c6_addr", o_imem_addr, 32'h200);
    tick();
    chk("t5_c7_ivalid", o_instr_valid, 0);
    chk("t5_c7_addr", o_imem_addr, 32'h204);
    tick();
    chk("t5_c8_pc", o_instr_pc, 32'h200);
    tick();
    chk("t5_c9_pc", o_instr_pc, 32'h204);
    i_instr_ready = 1'b0;
    repeat (4) tick();
    chk("t5_c13_req_valid", o_imem_req_valid, 0);
    chk("t5_c13_addr", o_imem_addr, 32'h214);
    chk("t5_c13_pc", o_instr_pc, 32'h204);
    chk("t5_c13_instr", o_instruction, dat(32'h204));

    // reset mid-stream with 3 in flight, 1 buffered
    do_reset(3, 1'b1);
    repeat (4) tick();
    chk("t6_pre_ivalid", o_instr_valid, 1);
    chk("t6_pre_pc", o_instr_pc, 32'h0);
    rstn = 1'b0;
    #1;
    chk("t6_rst_req_valid", o_imem_req_valid, 0);
    chk("t6_rst_ivalid", o_instr_valid, 0);
    chk("t6_rst_addr", o_imem_addr, 32'h0);
    chk("t6_rst_instr", o_instruction, 32'h0);
    chk("t6_rst_pc", o_instr_pc, 32'h0);
    lat = 1;
    repeat (2) tick();
    rstn = 1'b1;
    #1;
    chk("t6_c0_req_valid", o_imem_req_valid, 1);
    chk("t6_c0_addr", o_imem_addr, 32'h0);
    chk("t6_c0_ivalid", o_instr_valid, 0);
    tick();
    chk("t6_c1_ivalid", o_instr_valid, 0);
    tick();
    chk("t6_c2_ivalid", o_instr_valid, 1);
    chk("t6_c2_pc", o_instr_pc, 32'h0);
    chk("t6_c2_instr", o_instruction, dat(32'h0));
    tick();
    chk("t6_c3_pc", o_instr_pc, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
